// File: rtl/dm_cfg_regfile_if.sv
// ---------------------------------------------------------------------------
// dm_cfg_regfile_if
//   Host register port of the configuration register file: a valid/ready
//   request channel plus a response channel without backpressure.
//
//   Request  : cfg_valid_i, cfg_ready_o, cfg_we_i, cfg_addr_i, cfg_wdata_i
//   Response : rsp_valid_o, rsp_rdata_o, rsp_err_o
//
//   Modports
//     master : the host, which drives requests and receives responses
//     slave  : the register file
// ---------------------------------------------------------------------------
interface dm_cfg_regfile_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic              cfg_valid_i;
    logic              cfg_ready_o;
    logic              cfg_we_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [DATA_W-1:0] cfg_wdata_i;
    logic              rsp_valid_o;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport master (
        output cfg_valid_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cfg_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dm_cfg_regfile.sv
// ---------------------------------------------------------------------------
// dm_cfg_regfile
//   Run-time configuration register file for the digital Ising macro.
//   The host writes a shadow copy of every parameter; a commit copies the
//   shadow copy into the active copy only while the macro is idle, so the
//   macro never observes a half-written configuration.
//
//   Ports
//     clk_i, rst_ni          : clock, synchronous active-low reset
//     cfg                    : host register port (slave modport)
//     macro_busy_i           : macro running, commit is deferred while high
//     commit_pending_o       : a commit is waiting for the macro to go idle
//     cfg_updated_o          : one-cycle pulse after the active copy changed
//     en_comparison_o, flip_disable_o, enable_analog_loop_o, flush_o
//                            : active CTRL bits
//     icon_last_addr_plus_one_o, cycle_per_* , synchronizer_pipe_num_o
//                            : active scalar parameters
//     spin_wwl_strobe_o, spin_feedback_o
//                            : active spin vectors
//
//   Address map (word addresses, fields in the low bits)
//     0 CTRL, 1 icon bound, 2 wwl_high, 3 wwl_low, 4 spin_write,
//     5 spin_compute, 6 sync pipe count, 7 COMMIT/STATUS,
//     8 .. 8+SW-1 strobe words, 8+SW .. 8+2*SW-1 feedback words.
// ---------------------------------------------------------------------------
module dm_cfg_regfile #(
    parameter int NUM_SPIN         = 256,
    parameter int DATA_W           = 32,
    parameter int FLIP_ICON_DEPTH  = 1024,
    parameter int COUNTER_BITWIDTH = 16,
    parameter int SYNC_W           = 4,
    parameter int ADDR_W           = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    dm_cfg_regfile_if.slave                    cfg,
    input  logic                               macro_busy_i,
    output logic                               commit_pending_o,
    output logic                               cfg_updated_o,
    output logic                               en_comparison_o,
    output logic                               flip_disable_o,
    output logic                               enable_analog_loop_o,
    output logic                               flush_o,
    output logic [$clog2(FLIP_ICON_DEPTH):0]   icon_last_addr_plus_one_o,
    output logic [COUNTER_BITWIDTH-1:0]        cycle_per_wwl_high_o,
    output logic [COUNTER_BITWIDTH-1:0]        cycle_per_wwl_low_o,
    output logic [COUNTER_BITWIDTH-1:0]        cycle_per_spin_write_o,
    output logic [COUNTER_BITWIDTH-1:0]        cycle_per_spin_compute_o,
    output logic [SYNC_W-1:0]                  synchronizer_pipe_num_o,
    output logic [NUM_SPIN-1:0]                spin_wwl_strobe_o,
    output logic [NUM_SPIN-1:0]                spin_feedback_o
);

    localparam int ICON_W    = $clog2(FLIP_ICON_DEPTH) + 1;
    localparam int SW        = NUM_SPIN / DATA_W;
    localparam int STROBE_A  = 8;
    localparam int FEEDBK_A  = 8 + SW;
    localparam int NUM_WORDS = 8 + 2 * SW;
    localparam int COMMIT_A  = 7;

    typedef struct packed {
        logic [3:0]                  ctrl;
        logic [ICON_W-1:0]           icon;
        logic [COUNTER_BITWIDTH-1:0] wwl_high;
        logic [COUNTER_BITWIDTH-1:0] wwl_low;
        logic [COUNTER_BITWIDTH-1:0] spin_write;
        logic [COUNTER_BITWIDTH-1:0] spin_compute;
        logic [SYNC_W-1:0]           sync_pipe;
        logic [NUM_SPIN-1:0]         strobe;
        logic [NUM_SPIN-1:0]         feedback;
    } cfg_t;

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    // Power-on configuration, shared by shadow and active copies.
    function automatic cfg_t cfg_reset();
        cfg_t r;
        r.ctrl         = 4'b0101;
        r.icon         = ICON_W'(FLIP_ICON_DEPTH);
        r.wwl_high     = COUNTER_BITWIDTH'(5);
        r.wwl_low      = COUNTER_BITWIDTH'(5);
        r.spin_write   = COUNTER_BITWIDTH'(3);
        r.spin_compute = COUNTER_BITWIDTH'(7);
        r.sync_pipe    = SYNC_W'(3);
        r.strobe       = '1;
        r.feedback     = '1;
        return r;
    endfunction

    // Register read mux; narrow fields are zero-extended, unmapped reads give 0.
    function automatic logic [DATA_W-1:0] read_word(input cfg_t s, input int a,
                                                   input logic pend);
        logic [DATA_W-1:0] r;
        r = '0;
        case (a)
            0:        r = DATA_W'(s.ctrl);
            1:        r = DATA_W'(s.icon);
            2:        r = DATA_W'(s.wwl_high);
            3:        r = DATA_W'(s.wwl_low);
            4:        r = DATA_W'(s.spin_write);
            5:        r = DATA_W'(s.spin_compute);
            6:        r = DATA_W'(s.sync_pipe);
            COMMIT_A: r = DATA_W'(pend);
            default:  r = '0;
        endcase
        for (int k = 0; k < SW; k++) begin
            if (a == STROBE_A + k) r = s.strobe[k*DATA_W +: DATA_W];
            if (a == FEEDBK_A + k) r = s.feedback[k*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    // Field write into a configuration copy; upper bits beyond a field are dropped.
    function automatic cfg_t write_word(input cfg_t s, input int a,
                                        input logic [DATA_W-1:0] d);
        cfg_t r;
        r = s;
        case (a)
            0:       r.ctrl         = d[3:0];
            1:       r.icon         = d[ICON_W-1:0];
            2:       r.wwl_high     = d[COUNTER_BITWIDTH-1:0];
            3:       r.wwl_low      = d[COUNTER_BITWIDTH-1:0];
            4:       r.spin_write   = d[COUNTER_BITWIDTH-1:0];
            5:       r.spin_compute = d[COUNTER_BITWIDTH-1:0];
            6:       r.sync_pipe    = d[SYNC_W-1:0];
            default: r = s;
        endcase
        for (int k = 0; k < SW; k++) begin
            if (a == STROBE_A + k) r.strobe[k*DATA_W +: DATA_W]   = d;
            if (a == FEEDBK_A + k) r.feedback[k*DATA_W +: DATA_W] = d;
        end
        return r;
    endfunction

    state_t            state_q;
    state_t            state_d;
    cfg_t              shadow_q;
    cfg_t              active_q;
    logic              ready;
    logic              pending;
    logic              commit_fire;
    logic              accept;
    logic              mapped;
    logic              commit_req;
    int                addr_int;
    logic              rsp_vld_p1;
    logic              rsp_err_p1;
    logic [DATA_W-1:0] rsp_rdata_p1;
    logic              updated_p1;

    assign addr_int   = int'(cfg.cfg_addr_i);
    assign mapped     = (addr_int < NUM_WORDS);
    assign commit_req = cfg.cfg_we_i && (addr_int == COMMIT_A) && cfg.cfg_wdata_i[0];
    assign accept     = cfg.cfg_valid_i && ready;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // While a commit is pending the shadow copy is frozen: writes stall so the
    // copy that lands in the active registers is exactly the one requested.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b1;
        pending     = 1'b0;
        commit_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg.cfg_valid_i && commit_req) state_d = ST_PEND;
            end
            ST_PEND: begin
                pending = 1'b1;
                ready   = !cfg.cfg_we_i;
                if (!macro_busy_i) begin
                    commit_fire = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p0 -> p1: request accepted, response and register updates registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q     <= cfg_reset();
            active_q     <= cfg_reset();
            rsp_vld_p1   <= 1'b0;
            rsp_err_p1   <= 1'b0;
            rsp_rdata_p1 <= '0;
            updated_p1   <= 1'b0;
        end else begin
            rsp_vld_p1   <= accept;
            rsp_err_p1   <= accept && !mapped;
            rsp_rdata_p1 <= (accept && !cfg.cfg_we_i && mapped)
                            ? read_word(shadow_q, addr_int, pending) : '0;
            updated_p1   <= commit_fire;
            if (commit_fire) active_q <= shadow_q;
            if (accept && cfg.cfg_we_i && mapped)
                shadow_q <= write_word(shadow_q, addr_int, cfg.cfg_wdata_i);
        end
    end

    assign cfg.cfg_ready_o = ready;
    assign cfg.rsp_valid_o = rsp_vld_p1;
    assign cfg.rsp_err_o   = rsp_err_p1;
    assign cfg.rsp_rdata_o = rsp_rdata_p1;

    assign commit_pending_o          = pending;
    assign cfg_updated_o             = updated_p1;
    assign en_comparison_o           = active_q.ctrl[0];
    assign flip_disable_o            = active_q.ctrl[1];
    assign enable_analog_loop_o      = active_q.ctrl[2];
    assign flush_o                   = active_q.ctrl[3];
    assign icon_last_addr_plus_one_o = active_q.icon;
    assign cycle_per_wwl_high_o      = active_q.wwl_high;
    assign cycle_per_wwl_low_o       = active_q.wwl_low;
    assign cycle_per_spin_write_o    = active_q.spin_write;
    assign cycle_per_spin_compute_o  = active_q.spin_compute;
    assign synchronizer_pipe_num_o   = active_q.sync_pipe;
    assign spin_wwl_strobe_o         = active_q.strobe;
    assign spin_feedback_o           = active_q.feedback;

endmodule

// File: tb/tb_dm_cfg_regfile.sv
// ---------------------------------------------------------------------------
// tb_dm_cfg_regfile
//   Self-checking bench for dm_cfg_regfile with default parameters.
//   The reference model keeps the register map as plain word arrays
//   (shadow and active) plus a pending flag.
// ---------------------------------------------------------------------------
module tb_dm_cfg_regfile;
    localparam int NUM_SPIN = 256;
    localparam int DATA_W   = 32;
    localparam int SW       = NUM_SPIN / DATA_W;
    localparam int ICON_W   = 11;
    localparam int CW       = 16;
    localparam int SYNC_W   = 4;
    localparam int ADDR_W   = 8;
    localparam int NW       = 8 + 2 * SW;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic busy = 1'b0;

    logic                commit_pending, cfg_updated;
    logic                en_comparison, flip_disable, enable_analog_loop, flush;
    logic [ICON_W-1:0]   icon_bound;
    logic [CW-1:0]       wwl_high, wwl_low, spin_write, spin_compute;
    logic [SYNC_W-1:0]   sync_pipe;
    logic [NUM_SPIN-1:0] strobe, feedback;

    dm_cfg_regfile_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_cfg_regfile #(
        .NUM_SPIN(NUM_SPIN), .DATA_W(DATA_W), .FLIP_ICON_DEPTH(1024),
        .COUNTER_BITWIDTH(CW), .SYNC_W(SYNC_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i                     (clk),
        .rst_ni                    (rst_ni),
        .cfg                       (bus.slave),
        .macro_busy_i              (busy),
        .commit_pending_o          (commit_pending),
        .cfg_updated_o             (cfg_updated),
        .en_comparison_o           (en_comparison),
        .flip_disable_o            (flip_disable),
        .enable_analog_loop_o      (enable_analog_loop),
        .flush_o                   (flush),
        .icon_last_addr_plus_one_o (icon_bound),
        .cycle_per_wwl_high_o      (wwl_high),
        .cycle_per_wwl_low_o       (wwl_low),
        .cycle_per_spin_write_o    (spin_write),
        .cycle_per_spin_compute_o  (spin_compute),
        .synchronizer_pipe_num_o   (sync_pipe),
        .spin_wwl_strobe_o         (strobe),
        .spin_feedback_o           (feedback)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] sh  [NW];
    logic [31:0] act [NW];
    logic        pend_m;

    typedef struct {
        logic        we;
        int          addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] fmask(input int a);
        case (a)
            0, 6:       return 32'h0000_000F;
            1:          return 32'h0000_07FF;
            2, 3, 4, 5: return 32'h0000_FFFF;
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) sh[i] = 32'hFFFF_FFFF;
        sh[0] = 32'd5;    sh[1] = 32'd1024; sh[2] = 32'd5; sh[3] = 32'd5;
        sh[4] = 32'd3;    sh[5] = 32'd7;    sh[6] = 32'd3; sh[7] = 32'd0;
        for (int i = 0; i < NW; i++) act[i] = sh[i];
        pend_m = 1'b0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a < NW && a != 7) sh[a] = d & fmask(a);
    endtask

    task automatic model_read(input int a, output logic [31:0] rd, output logic er);
        er = (a >= NW);
        if (a == 7)       rd = {31'd0, pend_m};
        else if (a < NW)  rd = sh[a];
        else              rd = 32'd0;
    endtask

    task automatic check_active(input string tag);
        logic [NUM_SPIN-1:0] es, ef;
        for (int k = 0; k < SW; k++) begin
            es[k*32 +: 32] = act[8 + k];
            ef[k*32 +: 32] = act[8 + SW + k];
        end
        chk({tag, "_ctrl"}, 256'({flush, enable_analog_loop, flip_disable, en_comparison}),
            256'(act[0][3:0]));
        chk({tag, "_icon"}, 256'(icon_bound), 256'(act[1][ICON_W-1:0]));
        chk({tag, "_wwl_high"}, 256'(wwl_high), 256'(act[2][CW-1:0]));
        chk({tag, "_wwl_low"}, 256'(wwl_low), 256'(act[3][CW-1:0]));
        chk({tag, "_spin_write"}, 256'(spin_write), 256'(act[4][CW-1:0]));
        chk({tag, "_spin_compute"}, 256'(spin_compute), 256'(act[5][CW-1:0]));
        chk({tag, "_sync"}, 256'(sync_pipe), 256'(act[6][SYNC_W-1:0]));
        chk({tag, "_strobe"}, 256'(strobe), 256'(es));
        chk({tag, "_feedback"}, 256'(feedback), 256'(ef));
    endtask

    // Issue one request (called #1 after a rising edge), return the response.
    task automatic do_req(input logic we, input int a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er);
        bit got_ready = 1'b0;
        rd = 32'd0;
        er = 1'b0;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_we_i    = we;
        bus.cfg_addr_i  = 8'(a);
        bus.cfg_wdata_i = d;
        for (int n = 0; n < 50 && !got_ready; n++) begin
            @(negedge clk);
            got_ready = bus.cfg_ready_o;
        end
        if (!got_ready) begin
            chk("req_timeout", 256'(0), 256'(1));
            bus.cfg_valid_i = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        chk("rsp_valid", 256'(bus.rsp_valid_o), 256'(1));
        rd = bus.rsp_rdata_o;
        er = bus.rsp_err_o;
        @(posedge clk); #1;
        chk("rsp_single_pulse", 256'({bus.rsp_valid_o, bus.rsp_err_o}), 256'(0));
    endtask

    // Commit request held off by busy for busy_cycles edges, then released.
    task automatic commit_seq(input int busy_cycles, input logic [31:0] d);
        busy = (busy_cycles > 0);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 8'd7;
        bus.cfg_wdata_i = d | 32'd1;
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        pend_m = 1'b1;
        chk("commit_rsp", 256'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}),
            256'({1'b1, 1'b0, 32'd0}));
        for (int i = 0; i < busy_cycles; i++) begin
            chk("commit_wait_pending", 256'(commit_pending), 256'(1));
            chk("commit_wait_no_update", 256'(cfg_updated), 256'(0));
            check_active("commit_wait_active");
            @(posedge clk); #1;
        end
        chk("commit_pending", 256'(commit_pending), 256'(1));
        busy = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) act[i] = sh[i];
        pend_m = 1'b0;
        chk("commit_updated", 256'(cfg_updated), 256'(1));
        chk("commit_cleared", 256'(commit_pending), 256'(0));
        check_active("commit_active");
        @(posedge clk); #1;
        chk("commit_updated_pulse", 256'(cfg_updated), 256'(0));
    endtask

    initial begin
        logic [31:0] rd, exp_rd, d;
        logic        er, exp_er, we;
        int          a;

        bus.cfg_valid_i = 1'b0;
        bus.cfg_we_i    = 1'b0;
        bus.cfg_addr_i  = '0;
        bus.cfg_wdata_i = '0;
        model_reset();

        // Reset defaults
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pending", 256'(commit_pending), 256'(0));
        chk("rst_updated", 256'(cfg_updated), 256'(0));
        chk("rst_rsp", 256'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}), 256'(0));
        chk("rst_spin_compute", 256'(spin_compute), 256'(7));
        chk("rst_icon", 256'(icon_bound), 256'(1024));
        check_active("rst");
        rst_ni = 1'b1;

        // Vector table: {we, addr, wdata, expected rdata, expected err}
        tbl.push_back('{1'b0, 0,   32'h0,         32'h5,         1'b0});
        tbl.push_back('{1'b0, 1,   32'h0,         32'd1024,      1'b0});
        tbl.push_back('{1'b0, 2,   32'h0,         32'h5,         1'b0});
        tbl.push_back('{1'b0, 3,   32'h0,         32'h5,         1'b0});
        tbl.push_back('{1'b0, 4,   32'h0,         32'h3,         1'b0});
        tbl.push_back('{1'b0, 5,   32'h0,         32'h7,         1'b0});
        tbl.push_back('{1'b0, 6,   32'h0,         32'h3,         1'b0});
        tbl.push_back('{1'b0, 7,   32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b0, 8,   32'h0,         32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{1'b0, 23,  32'h0,         32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{1'b1, 2,   32'd9,         32'h0,         1'b0});
        tbl.push_back('{1'b0, 2,   32'h0,         32'd9,         1'b0});
        tbl.push_back('{1'b1, 1,   32'hFFFF_FFFF, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 1,   32'h0,         32'h7FF,       1'b0});
        tbl.push_back('{1'b1, 24,  32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, 255, 32'h1234,      32'h0,         1'b1});
        tbl.push_back('{1'b0, 24,  32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b0, 200, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{1'b1, 0,   32'hFFFF_FFFA, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 0,   32'h0,         32'hA,         1'b0});
        tbl.push_back('{1'b1, 19,  32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b0, 19,  32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b0, 18,  32'h0,         32'hFFFF_FFFF, 1'b0});
        tbl.push_back('{1'b1, 6,   32'h1A,        32'h0,         1'b0});
        tbl.push_back('{1'b0, 6,   32'h0,         32'hA,         1'b0});
        tbl.push_back('{1'b1, 7,   32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b0, 7,   32'h0,         32'h0,         1'b0});
        tbl.push_back('{1'b1, 5,   32'h1234_5678, 32'h0,         1'b0});
        tbl.push_back('{1'b0, 5,   32'h0,         32'h5678,      1'b0});
        tbl.push_back('{1'b0, 3,   32'h0,         32'h5,         1'b0});

        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, er);
            chk($sformatf("tbl%0d_rdata", i), 256'(rd), 256'(tbl[i].rdata));
            chk($sformatf("tbl%0d_err", i), 256'(er), 256'(tbl[i].err));
            if (tbl[i].we) model_write(tbl[i].addr, tbl[i].wdata);
        end
        chk("shadow_isolation_wwl_high", 256'(wwl_high), 256'(5));
        check_active("pre_commit");

        // Deferred commit: status read served, writes stall, commit on busy drop
        busy = 1'b1;
        bus.cfg_valid_i = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 8'd7;
        bus.cfg_wdata_i = 32'd1;
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        pend_m = 1'b1;
        do_req(1'b0, 7, 32'd0, rd, er);
        chk("status_read", 256'({er, rd}), 256'({1'b0, 32'd1}));
        bus.cfg_valid_i = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 8'd3;
        bus.cfg_wdata_i = 32'd11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 256'(bus.cfg_ready_o), 256'(0));
            chk("stall_no_update", 256'(cfg_updated), 256'(0));
        end
        check_active("busy_hold");
        busy = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < NW; i++) act[i] = sh[i];
        pend_m = 1'b0;
        chk("deferred_updated", 256'(cfg_updated), 256'(1));
        chk("deferred_pending", 256'(commit_pending), 256'(0));
        chk("deferred_wwl_high", 256'(wwl_high), 256'(9));
        chk("fb_word3_zero", 256'(feedback[127:96]), 256'(0));
        chk("fb_other_ones", 256'(feedback | {128'd0, 32'hFFFF_FFFF, 96'd0}),
            256'({NUM_SPIN{1'b1}}));
        check_active("deferred");
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        chk("stalled_write_accepted", 256'({bus.rsp_valid_o, bus.rsp_err_o}), 256'(2));
        chk("deferred_pulse_once", 256'(cfg_updated), 256'(0));
        model_write(3, 32'd11);
        @(posedge clk); #1;
        do_req(1'b0, 3, 32'd0, rd, er);
        chk("stalled_write_data", 256'(rd), 256'(11));
        chk("active_wwl_low_unchanged", 256'(wwl_low), 256'(5));

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NW, 255))
                                              : int'($urandom_range(0, NW - 1));
            d  = $urandom;
            if (we && a == 7 && d[0]) begin
                commit_seq(int'($urandom_range(0, 3)), d);
            end else begin
                busy = 1'($urandom_range(0, 1));
                model_read(a, exp_rd, exp_er);
                do_req(we, a, d, rd, er);
                if (we) exp_rd = 32'd0;
                chk($sformatf("rand%0d_rdata", it), 256'(rd), 256'(exp_rd));
                chk($sformatf("rand%0d_err", it), 256'(er), 256'(exp_er));
                if (we) model_write(a, d);
                check_active($sformatf("rand%0d", it));
            end
        end
        commit_seq(2, 32'd1);

        // Reset while a commit is pending
        busy = 1'b1;
        do_req(1'b1, 4, 32'd99, rd, er);
        bus.cfg_valid_i = 1'b1;
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = 8'd7;
        bus.cfg_wdata_i = 32'd1;
        @(posedge clk); #1;
        bus.cfg_valid_i = 1'b0;
        chk("midpend_pending", 256'(commit_pending), 256'(1));
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        model_reset();
        chk("midpend_rst_pending", 256'(commit_pending), 256'(0));
        chk("midpend_rst_updated", 256'(cfg_updated), 256'(0));
        chk("midpend_rst_rsp", 256'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_rdata_o}), 256'(0));
        check_active("midpend_rst");
        rst_ni = 1'b1;
        busy   = 1'b0;
        @(posedge clk); #1;
        chk("midpend_no_pulse", 256'(cfg_updated), 256'(0));
        check_active("midpend_after");
        do_req(1'b0, 4, 32'd0, rd, er);
        chk("midpend_shadow_reset", 256'(rd), 256'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
